// File: rtl/retire_trace_queue.sv
// Retire trace queue: circular buffer of fetched {addr, instr} pairs popped in order at retire,
// with flush, registered retire output, wrapping retire counter and sticky error flags.
module retire_trace_queue #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid,
  input  logic [ADDR_WIDTH-1:0]    fetch_addr,
  input  logic [INSTR_WIDTH-1:0]   fetch_instr,
  input  logic                     retire_valid,
  input  logic                     flush,
  input  logic                     clear_err,
  output logic                     head_valid,
  output logic [ADDR_WIDTH-1:0]    head_addr,
  output logic [INSTR_WIDTH-1:0]   head_instr,
  output logic                     ret_valid,
  output logic [ADDR_WIDTH-1:0]    ret_addr,
  output logic [INSTR_WIDTH-1:0]   ret_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_WIDTH-1:0]     retire_cnt,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = PtrW + 1;

  logic [ADDR_WIDTH-1:0]  addr_mem  [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        wr_base;
  logic [CountW-1:0]      count_q, count_d;
  logic [CNT_WIDTH-1:0]   retire_cnt_q, retire_cnt_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   ret_valid_q;
  logic [ADDR_WIDTH-1:0]  ret_addr_q;
  logic [INSTR_WIDTH-1:0] ret_instr_q;

  logic do_retire, underflow_evt;
  logic room, do_push, overflow_evt;

  // Events resolve in the order retire, flush, push: a push sees the queue after both.
  always_comb begin
    do_retire     = retire_valid && (count_q != '0);
    underflow_evt = retire_valid && (count_q == '0);
    room          = (count_q != CountW'(DEPTH)) || do_retire || flush;
    do_push       = fetch_valid && room;
    overflow_evt  = fetch_valid && !room;

    rd_ptr_d      = flush ? '0 : rd_ptr_q + PtrW'(do_retire);
    wr_base       = flush ? '0 : wr_ptr_q;
    wr_ptr_d      = wr_base + PtrW'(do_push);
    count_d       = (flush ? '0 : count_q - CountW'(do_retire)) + CountW'(do_push);
    retire_cnt_d  = retire_cnt_q + CNT_WIDTH'(do_retire);

    // A new error wins over a same-cycle clear.
    overflow_d    = overflow_evt  || (overflow_q  && !clear_err);
    underflow_d   = underflow_evt || (underflow_q && !clear_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      retire_cnt_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ret_valid_q  <= 1'b0;
      ret_addr_q   <= '0;
      ret_instr_q  <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      retire_cnt_q <= retire_cnt_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      ret_valid_q  <= do_retire;
      if (do_retire) begin
        ret_addr_q  <= addr_mem[rd_ptr_q];
        ret_instr_q <= instr_mem[rd_ptr_q];
      end
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_base]  <= fetch_addr;
      instr_mem[wr_base] <= fetch_instr;
    end
  end

  always_comb begin
    head_valid = (count_q != '0);
    head_addr  = addr_mem[rd_ptr_q];
    head_instr = instr_mem[rd_ptr_q];
    ret_valid  = ret_valid_q;
    ret_addr   = ret_addr_q;
    ret_instr  = ret_instr_q;
    count      = count_q;
    retire_cnt = retire_cnt_q;
    overflow   = overflow_q;
    underflow  = underflow_q;
  end

endmodule

// File: tb/tb_retire_trace_queue.sv
// Self-checking bench for retire_trace_queue: a queue model tracks contents and a scoreboard
// of expected retired entries is filled at drive time and drained when ret_valid appears.
module tb_retire_trace_queue;

  localparam int unsigned DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [15:0] fetch_addr;
  logic [15:0] fetch_instr;
  logic        retire_valid;
  logic        flush;
  logic        clear_err;
  logic        head_valid;
  logic [15:0] head_addr;
  logic [15:0] head_instr;
  logic        ret_valid;
  logic [15:0] ret_addr;
  logic [15:0] ret_instr;
  logic [3:0]  count;
  logic [3:0]  retire_cnt;
  logic        overflow;
  logic        underflow;

  retire_trace_queue #(
    .ADDR_WIDTH (16),
    .INSTR_WIDTH(16),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .retire_valid(retire_valid),
    .flush       (flush),
    .clear_err   (clear_err),
    .head_valid  (head_valid),
    .head_addr   (head_addr),
    .head_instr  (head_instr),
    .ret_valid   (ret_valid),
    .ret_addr    (ret_addr),
    .ret_instr   (ret_instr),
    .count       (count),
    .retire_cnt  (retire_cnt),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model[$];
  logic [31:0] exp_q[$];
  logic [3:0]  m_rcnt = '0;
  logic        m_ovf  = 1'b0;
  logic        m_unf  = 1'b0;

  // Drive one cycle, update the model in retire/flush/push order, advance past the edge.
  task automatic cycle(input logic fv, input logic [15:0] fa, input logic [15:0] fi,
                       input logic rv, input logic fl, input logic ce);
    logic ovf_evt, unf_evt;
    fetch_valid  = fv;
    fetch_addr   = fa;
    fetch_instr  = fi;
    retire_valid = rv;
    flush        = fl;
    clear_err    = ce;
    unf_evt = rv && (model.size() == 0);
    if (rv && model.size() != 0) begin
      exp_q.push_back(model.pop_front());
      m_rcnt = m_rcnt + 4'd1;
    end
    if (fl) model.delete();
    ovf_evt = 1'b0;
    if (fv) begin
      if (model.size() < DEPTH) model.push_back({fa, fi});
      else ovf_evt = 1'b1;
    end
    m_ovf = ovf_evt | (m_ovf & ~ce);
    m_unf = unf_evt | (m_unf & ~ce);
    @(posedge clk);
    #1;
    fetch_valid  = 1'b0;
    retire_valid = 1'b0;
    flush        = 1'b0;
    clear_err    = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    tests_run++;
    if ({head_valid, ret_valid, ret_addr, ret_instr, count, retire_cnt, overflow, underflow}
        !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got hv=%0b rv=%0b ra=%h ri=%h cnt=%0d rc=%0d ovf=%0b unf=%0b, want all 0",
               head_valid, ret_valid, ret_addr, ret_instr, count, retire_cnt, overflow, underflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_in_order;
    logic [31:0] e;
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(i), 16'hA000 + 16'(i), 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (count !== 4'd3 || head_valid !== 1'b1 || head_addr !== 16'h0000) begin
      tests_failed++;
      $display("FAIL in_order_fill: got cnt=%0d hv=%0b ha=%h, want cnt=3 hv=1 ha=0000",
               count, head_valid, head_addr);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
      tests_run++;
      if (ret_valid !== 1'b1 || {ret_addr, ret_instr} !== e || count !== 4'(model.size())) begin
        tests_failed++;
        $display("FAIL in_order_retire%0d: got rv=%0b ret=%h cnt=%0d, want rv=1 ret=%h cnt=%0d",
                 i, ret_valid, {ret_addr, ret_instr}, count, e, model.size());
      end
    end
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (ret_valid !== 1'b0 || retire_cnt !== m_rcnt || head_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL in_order_done: got rv=%0b rc=%0d hv=%0b, want rv=0 rc=%0d hv=0",
               ret_valid, retire_cnt, head_valid, m_rcnt);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] e;
    for (int i = 0; i < 9; i++)
      cycle(1'b1, 16'h0100 + 16'(i), 16'hB000 + 16'(i), 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (count !== 4'd8 || overflow !== 1'b1 || head_addr !== 16'h0100) begin
      tests_failed++;
      $display("FAIL overflow_full: got cnt=%0d ovf=%0b ha=%h, want cnt=8 ovf=1 ha=0100",
               count, overflow, head_addr);
    end
    cycle(1'b1, 16'h0109, 16'hB009, 1'b1, 1'b0, 1'b0);
    e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
    tests_run++;
    if (count !== 4'd8 || overflow !== m_ovf || head_addr !== 16'h0101 ||
        ret_valid !== 1'b1 || {ret_addr, ret_instr} !== e) begin
      tests_failed++;
      $display("FAIL overflow_retire_push: got cnt=%0d ovf=%0b ha=%h rv=%0b ret=%h, want 8 %0b 0101 1 %h",
               count, overflow, head_addr, ret_valid, {ret_addr, ret_instr}, m_ovf, e);
    end
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_clear: got ovf=%0b, want 0", overflow);
    end
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (count !== 4'd0 || head_valid !== 1'b0 || retire_cnt !== m_rcnt) begin
      tests_failed++;
      $display("FAIL overflow_flush: got cnt=%0d hv=%0b rc=%0d, want 0 0 %0d",
               count, head_valid, retire_cnt, m_rcnt);
    end
  endtask

  task automatic test_full_flush_push;
    logic [31:0] e;
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 16'h0300 + 16'(i), 16'hD000 + 16'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0380, 16'hD080, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (count !== 4'd1 || head_addr !== 16'h0380 || head_instr !== 16'hD080 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_flush_push: got cnt=%0d ha=%h hi=%h ovf=%0b, want 1 0380 d080 0",
               count, head_addr, head_instr, overflow);
    end
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
    tests_run++;
    if (ret_valid !== 1'b1 || {ret_addr, ret_instr} !== e || count !== 4'd0) begin
      tests_failed++;
      $display("FAIL full_flush_drain: got rv=%0b ret=%h cnt=%0d, want 1 %h 0",
               ret_valid, {ret_addr, ret_instr}, count, e);
    end
  endtask

  task automatic test_flush_combo;
    logic [31:0] e;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 16'h0010 + 16'(i), 16'hC010 + 16'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0020, 16'hC020, 1'b1, 1'b1, 1'b0);
    e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
    tests_run++;
    if (ret_valid !== 1'b1 || ret_addr !== 16'h0010 || {ret_addr, ret_instr} !== e) begin
      tests_failed++;
      $display("FAIL flush_combo_ret: got rv=%0b ret=%h, want rv=1 ret=%h", ret_valid,
               {ret_addr, ret_instr}, e);
    end
    tests_run++;
    if (count !== 4'd1 || head_addr !== 16'h0020 || retire_cnt !== m_rcnt) begin
      tests_failed++;
      $display("FAIL flush_combo_state: got cnt=%0d ha=%h rc=%0d, want 1 0020 %0d",
               count, head_addr, retire_cnt, m_rcnt);
    end
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
    tests_run++;
    if (ret_valid !== 1'b1 || {ret_addr, ret_instr} !== e || count !== 4'd0) begin
      tests_failed++;
      $display("FAIL flush_combo_drain: got rv=%0b ret=%h cnt=%0d, want 1 %h 0",
               ret_valid, {ret_addr, ret_instr}, count, e);
    end
  endtask

  task automatic test_underflow;
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (underflow !== 1'b1 || ret_valid !== 1'b0 || count !== 4'd0) begin
      tests_failed++;
      $display("FAIL underflow_set: got unf=%0b rv=%0b cnt=%0d, want 1 0 0",
               underflow, ret_valid, count);
    end
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (underflow !== m_unf) begin
      tests_failed++;
      $display("FAIL underflow_err_wins: got unf=%0b, want %0b", underflow, m_unf);
    end
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (underflow !== 1'b0 || retire_cnt !== m_rcnt) begin
      tests_failed++;
      $display("FAIL underflow_clear: got unf=%0b rc=%0d, want 0 %0d", underflow, retire_cnt,
               m_rcnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    cycle(1'b1, 16'h0400, 16'hE400, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 16'h0401 + 16'(i), 16'hE401 + 16'(i), 1'b1, 1'b0, 1'b0);
      e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
      tests_run++;
      if (ret_valid !== 1'b1 || {ret_addr, ret_instr} !== e || count !== 4'd1) begin
        tests_failed++;
        $display("FAIL back_to_back%0d: got rv=%0b ret=%h cnt=%0d, want 1 %h 1",
                 i, ret_valid, {ret_addr, ret_instr}, count, e);
      end
    end
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hxxxx_xxxx;
    tests_run++;
    if ({ret_addr, ret_instr} !== e || count !== 4'd0 || retire_cnt !== m_rcnt) begin
      tests_failed++;
      $display("FAIL back_to_back_end: got ret=%h cnt=%0d rc=%0d, want %h 0 %0d",
               {ret_addr, ret_instr}, count, retire_cnt, e, m_rcnt);
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 16'h0500 + 16'(i), 16'hF500 + 16'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'h0510, 16'hF510, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model.delete();
    exp_q.delete();
    m_rcnt = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    #1;
    tests_run++;
    if ({head_valid, ret_valid, ret_addr, ret_instr, count, retire_cnt, overflow, underflow}
        !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got hv=%0b rv=%0b ra=%h ri=%h cnt=%0d rc=%0d ovf=%0b unf=%0b, want all 0",
               head_valid, ret_valid, ret_addr, ret_instr, count, retire_cnt, overflow, underflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 16'h0600, 16'hA600, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (count !== 4'd1 || head_valid !== 1'b1 || head_addr !== 16'h0600) begin
      tests_failed++;
      $display("FAIL reset_first_push: got cnt=%0d hv=%0b ha=%h, want 1 1 0600",
               count, head_valid, head_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    fetch_valid  = 1'b0;
    fetch_addr   = '0;
    fetch_instr  = '0;
    retire_valid = 1'b0;
    flush        = 1'b0;
    clear_err    = 1'b0;
    test_reset();
    test_in_order();
    test_overflow();
    test_full_flush_push();
    test_flush_combo();
    test_underflow();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
